exclusivity_monitor: RTL

//   Synthesizable run-time checker for exclusivity rules on NUM_CH control signals
//   (grants, selects, enables). Generalises the two-signal "never both high" property
//   to N channels with three rule modes. Adds a run-length fault threshold, a saturating

---
 rtl/exclusivity_monitor.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/exclusivity_monitor.sv
// -----------------------------------------------------------------------------
// exclusivity_monitor
//   Run-time checker for exclusivity rules on NUM_CH control signals (grants,
//   selects, enables). One rule is applied per cycle to the monitored vector:
//     MODE 0 : at most one signal high
//     MODE 1 : exactly one signal high
//     MODE 2 : not all signals high
//   The monitor also provides the following tracking:
//     - a saturating count of violating samples
//     - a saturating run-length of consecutive violating samples, which drives
//       a sticky FAULT state once it reaches FAULT_THRESH
//     - capture of the vector and timestamp of the first violation
//
// Ports
//   clock      in   rising-edge clock
//   rst_n      in   synchronous reset, active low (beats clear)
//   enable     in   1 = sample sig this cycle, 0 = hold state (FSM parks in IDLE)
//   clear      in   synchronous clear of status, counters and capture
//   sig        in   [NUM_CH]  monitored signals
//   violation  out  rule failed on the previous enabled sample
//   err_sticky out  set on first violation, held until clear/reset
//   fault      out  1 while the FSM is in FAULT
//   viol_count out  [CNT_W]   total violating samples, saturating
//   first_vec  out  [NUM_CH]  sig at first violation
//   first_ts   out  [TS_W]    timestamp at first violation
//   timestamp  out  [TS_W]    enabled-cycle counter, saturating
// -----------------------------------------------------------------------------
module exclusivity_monitor #(
  parameter int NUM_CH       = 2,
  parameter int MODE         = 0,
  parameter int CNT_W        = 8,
  parameter int TS_W         = 16,
  parameter int FAULT_THRESH = 1
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              clear,
  input  logic [NUM_CH-1:0] sig,
  output logic              violation,
  output logic              err_sticky,
  output logic              fault,
  output logic [CNT_W-1:0]  viol_count,
  output logic [NUM_CH-1:0] first_vec,
  output logic [TS_W-1:0]   first_ts,
  output logic [TS_W-1:0]   timestamp
);

  localparam int POP_W = $clog2(NUM_CH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [TS_W-1:0]  TS_MAX  = '1;

  // Parameter legality is checked at elaboration
  if (NUM_CH < 2) begin : g_bad_num_ch
    $error("exclusivity_monitor: NUM_CH must be >= 2");
  end
  if (MODE < 0 || MODE > 2) begin : g_bad_mode
    $error("exclusivity_monitor: MODE must be 0, 1 or 2");
  end
  if (FAULT_THRESH < 1 || 64'(FAULT_THRESH) > ((64'd1 << CNT_W) - 64'd1)) begin : g_bad_thresh
    $error("exclusivity_monitor: FAULT_THRESH out of range 1..2**CNT_W-1");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic             fault_latched;
  logic [CNT_W-1:0] run_len;

  logic [POP_W-1:0] pop;
  logic             rule_hit;
  logic             sig_unknown;
  logic             viol;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] run_inc;
  logic [TS_W-1:0]  ts_inc;
  logic             thresh_hit;

  // ---------------------------------------------------------------------------
  // Rule evaluation
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: combinational blocks use blocking '=', clocked blocks use '<='.
    pop = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pop = pop + POP_W'(sig[i]);
    end
  end

  if (MODE == 0) begin : g_mode_at_most_one
    assign rule_hit = (pop > POP_W'(1));
  end else if (MODE == 1) begin : g_mode_exactly_one
    assign rule_hit = (pop != POP_W'(1));
  end else begin : g_mode_not_all
    // All bits set is the same as popcount equal to the width.
    assign rule_hit = (pop == POP_W'(NUM_CH));
  end

  // An unknown sample counts as a violation in simulation. This keeps X out
  // of the counters, because the forced 1 dominates the OR.
`ifdef SYNTHESIS
  assign sig_unknown = 1'b0;
`else
  assign sig_unknown = $isunknown(sig);
`endif

  assign viol = sig_unknown | rule_hit;

  // Saturating increments
  assign cnt_inc    = (viol_count == CNT_MAX) ? viol_count : viol_count + CNT_W'(1);
  assign run_inc    = (run_len    == CNT_MAX) ? run_len    : run_len    + CNT_W'(1);
  assign ts_inc     = (timestamp  == TS_MAX)  ? timestamp  : timestamp  + TS_W'(1);
  assign thresh_hit = viol && (run_inc >= CNT_W'(FAULT_THRESH));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default first so every path assigns state_nxt (no inferred latch).
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (enable) begin
          state_nxt = (fault_latched || thresh_hit) ? ST_FAULT : ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (!enable) begin
          state_nxt = ST_IDLE;
        end else if (thresh_hit) begin
          state_nxt = ST_FAULT;
        end
      end
      ST_FAULT: begin
        // Sticky: only a disabled cycle parks it in IDLE. The latch brings
        // it straight back once sampling resumes.
        if (!enable) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (clear) begin
      state_nxt = enable ? ST_ARMED : ST_IDLE;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    fault = (state == ST_FAULT);
  end

  // ---------------------------------------------------------------------------
  // Status, counters and first-failure capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!rst_n || clear) begin
      violation     <= 1'b0;
      err_sticky    <= 1'b0;
      viol_count    <= '0;
      first_vec     <= '0;
      first_ts      <= '0;
      timestamp     <= '0;
      run_len       <= '0;
      fault_latched <= 1'b0;
    end else if (enable) begin
      violation <= viol;
      timestamp <= ts_inc;
      if (viol) begin
        viol_count <= cnt_inc;
        run_len    <= run_inc;
        if (!err_sticky) begin
          err_sticky <= 1'b1;
          first_vec  <= sig;
          first_ts   <= timestamp;   // pre-increment value of this cycle
        end
      end else begin
        run_len <= '0;
      end
      if (state_nxt == ST_FAULT) begin
        fault_latched <= 1'b1;
      end
    end else begin
      violation <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Embedded checks (simulation only)
  // ---------------------------------------------------------------------------
`ifndef SYNTHESIS
  a_sig_known : assert property (@(posedge clock)
    (rst_n && enable) |-> !$isunknown(sig))
    else $error("exclusivity_monitor: unknown value on sig");

  a_rule_flag : assert property (@(posedge clock)
    (rst_n && enable && !clear) |=> (violation == $past(viol)))
    else $error("exclusivity_monitor: violation flag disagrees with MODE %0d rule", MODE);

  a_count_mono : assert property (@(posedge clock)
    (rst_n && !clear) |=> (viol_count >= $past(viol_count)))
    else $error("exclusivity_monitor: viol_count decreased without clear/reset");

  a_fault_err : assert property (@(posedge clock) disable iff (!rst_n)
    fault |-> err_sticky)
    else $error("exclusivity_monitor: fault without err_sticky");
`endif

endmodule
